// File: rtl/y86_pkg.sv
// Shared definitions for the Y86 stage sequencer: instruction codes,
// status codes, the sequencer state set and a counter increment helper.
package y86_pkg;

    // Instruction codes as presented by the fetch unit
    localparam logic [3:0] IHALT   = 4'd0;
    localparam logic [3:0] INOP    = 4'd1;
    localparam logic [3:0] IRRMOVQ = 4'd2;
    localparam logic [3:0] IIRMOVQ = 4'd3;
    localparam logic [3:0] IRMMOVQ = 4'd4;
    localparam logic [3:0] IMRMOVQ = 4'd5;
    localparam logic [3:0] IOPQ    = 4'd6;
    localparam logic [3:0] IJXX    = 4'd7;
    localparam logic [3:0] ICALL   = 4'd8;
    localparam logic [3:0] IRET    = 4'd9;
    localparam logic [3:0] IPUSHQ  = 4'd10;
    localparam logic [3:0] IPOPQ   = 4'd11;

    // Processor status codes
    typedef enum logic [2:0] {
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_ADR = 3'd3,
        STAT_INS = 3'd4
    } stat_t;

    // Sequencer states
    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBACK,
        S_PCUPD,
        S_PAUSE,
        S_STOP
    } state_t;

    // Increment a 32-bit counter, either holding at all-ones or wrapping
    function automatic logic [31:0] cnt_inc(input logic [31:0] value, input logic sat);
        if (sat && (&value))
            return value;
        return value + 32'd1;
    endfunction

endpackage

// File: rtl/pc_select.sv
// Combinational next-PC selection from the instruction code and the
// condition bit captured during execute. Plain selection, no adjustment.
module pc_select
    import y86_pkg::*;
(
    input  logic [3:0]  icode,
    input  logic        cnd,
    input  logic [63:0] valC,
    input  logic [63:0] valP,
    input  logic [63:0] valM,
    output logic [63:0] new_pc
);

    // Pick the branch target, return address or fall-through address
    always_comb begin
        // NOTE: a default assignment first keeps every path driven, so no latch is inferred.
        new_pc = valP;
        case (icode)
            ICALL:   new_pc = valC;
            IJXX:    new_pc = cnd ? valC : valP;
            IRET:    new_pc = valM;
            default: new_pc = valP;
        endcase
    end

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle Y86 stage sequencer: walks each instruction through
// fetch, decode, execute, memory, writeback and PC update, with
// optional single-step pausing, error stop and retire/busy counters.
module stage_sequencer
    import y86_pkg::*;
#(
    parameter logic [63:0] START_PC = 64'd0,
    parameter logic        SAT_CNT  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        step_mode,
    input  logic        step,
    input  logic [3:0]  icode,
    input  logic        instr_val,
    input  logic        imem_er,
    input  logic        halt,
    input  logic        cnd,
    input  logic [63:0] valC,
    input  logic [63:0] valP,
    input  logic [63:0] valM,
    input  logic        dmem_er,
    output logic [63:0] pc,
    output logic        fetch_en,
    output logic        decode_en,
    output logic        exec_en,
    output logic        mem_en,
    output logic        wb_en,
    output logic [2:0]  stat,
    output logic        busy,
    output logic [31:0] instr_count,
    output logic [31:0] cycle_count
);

    state_t      state;
    state_t      nxt_state;
    stat_t       stat_q;
    stat_t       nxt_stat;
    logic        cnd_q;
    logic [1:0]  rst_sync;
    logic        run_ok;
    logic [63:0] new_pc;
    logic        launch;

    assign stat   = stat_q;
    assign run_ok = rst_sync[1];
    assign launch = (state == S_IDLE) && (nxt_state == S_FETCH);

    pc_select u_pc_select (
        .icode  (icode),
        .cnd    (cnd_q),
        .valC   (valC),
        .valP   (valP),
        .valM   (valM),
        .new_pc (new_pc)
    );

    // Reset release is re-timed so the sequencer leaves IDLE only after two clean edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rst_sync <= 2'b00;
        else
            rst_sync <= {rst_sync[0], 1'b1};
    end

    // Next-state and next-status decision for the current stage
    always_comb begin
        nxt_state = state;
        nxt_stat  = stat_q;
        case (state)
            S_IDLE: begin
                if (start && run_ok) begin
                    nxt_state = S_FETCH;
                    nxt_stat  = STAT_AOK;
                end
            end
            S_FETCH: begin
                if (imem_er) begin
                    nxt_state = S_STOP;
                    nxt_stat  = STAT_ADR;
                end else if (!instr_val) begin
                    nxt_state = S_STOP;
                    nxt_stat  = STAT_INS;
                end else if (halt) begin
                    nxt_state = S_STOP;
                    nxt_stat  = STAT_HLT;
                end else begin
                    nxt_state = S_DECODE;
                end
            end
            S_DECODE:    nxt_state = S_EXECUTE;
            S_EXECUTE:   nxt_state = S_MEMORY;
            S_MEMORY: begin
                if (dmem_er) begin
                    nxt_state = S_STOP;
                    nxt_stat  = STAT_ADR;
                end else begin
                    nxt_state = S_WRITEBACK;
                end
            end
            S_WRITEBACK: nxt_state = S_PCUPD;
            S_PCUPD:     nxt_state = step_mode ? S_PAUSE : S_FETCH;
            S_PAUSE:     nxt_state = step ? S_FETCH : S_PAUSE;
            S_STOP:      nxt_state = S_STOP;
            default:     nxt_state = S_IDLE;
        endcase
    end

    // Registered state, status, strobes, PC, condition bit and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            stat_q      <= STAT_AOK;
            pc          <= START_PC;
            cnd_q       <= 1'b0;
            fetch_en    <= 1'b0;
            decode_en   <= 1'b0;
            exec_en     <= 1'b0;
            mem_en      <= 1'b0;
            wb_en       <= 1'b0;
            busy        <= 1'b0;
            instr_count <= 32'd0;
            cycle_count <= 32'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state     <= nxt_state;
            stat_q    <= nxt_stat;
            fetch_en  <= (nxt_state == S_FETCH);
            decode_en <= (nxt_state == S_DECODE);
            exec_en   <= (nxt_state == S_EXECUTE);
            mem_en    <= (nxt_state == S_MEMORY);
            wb_en     <= (nxt_state == S_WRITEBACK);
            busy      <= (nxt_state != S_IDLE) && (nxt_state != S_STOP);

            if (state == S_EXECUTE)
                cnd_q <= cnd;

            if (launch)
                pc <= START_PC;
            else if (state == S_PCUPD)
                pc <= new_pc;

            if (launch) begin
                instr_count <= 32'd0;
                cycle_count <= 32'd0;
            end else begin
                if (busy)
                    cycle_count <= cnt_inc(cycle_count, SAT_CNT);
                if (state == S_PCUPD)
                    instr_count <= cnt_inc(instr_count, SAT_CNT);
            end
        end
    end

endmodule

// File: doc/stage_sequencer.md
STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 Parameter: START_PC, 64'd0, PC loaded on reset and on start.
REQ-002 Parameter: SAT_CNT, 1, 1 = both counters saturate at all-ones; 0 = counters wrap.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  begin execution from START_PC; honoured only in IDLE.
REQ-006 step_mode  in  1  1 = pause after every instruction.
REQ-007 step  in  1  release from PAUSE; honoured only in PAUSE.
REQ-008 icode  in  4  from fetch; valid in FETCH and held thereafter.
REQ-009 instr_val, imem_er, halt  in  1 each  fetch status, sampled in FETCH.
REQ-010 cnd  in  1  execute condition bit, sampled in EXECUTE.
REQ-011 valC, valP, valM  in  64 each  next-PC candidates, sampled in PCUPD.
REQ-012 dmem_er  in  1  data-memory error, sampled in MEMORY.
REQ-013 pc  out  64  current instruction address.
REQ-014 fetch_en, decode_en, exec_en, mem_en, wb_en  out  1 each  one-hot stage strobes.
REQ-015 stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS.
REQ-016 busy  out  1  high in any state except IDLE and STOP.
REQ-017 instr_count, cycle_count  out  32 each  retired instructions / busy cycles.

Function
REQ-018 States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, PAUSE, STOP; each occupies exactly one cycle except IDLE, PAUSE and STOP.
REQ-019 IDLE->FETCH on start=1; pc<=START_PC, stat<=AOK, counters<=0 on that edge.
REQ-020 Sequence FETCH->DECODE->EXECUTE->MEMORY->WRITEBACK->PCUPD; one instruction = 6 cycles.
REQ-021 Each stage strobe is high only in its own state; no strobe in PCUPD, PAUSE, IDLE or STOP.
REQ-022 FETCH error priority: imem_er -> stat=ADR; else !instr_val -> INS; else halt -> HLT; on any of these go to STOP.
REQ-023 On a FETCH error: pc unchanged; instruction not counted; no later strobes issued.
REQ-024 dmem_er=1 in MEMORY -> stat=ADR, go to STOP; wb_en is never asserted for that instruction; pc unchanged.
REQ-025 cnd is registered in EXECUTE and used in PCUPD.
REQ-026 Next PC in PCUPD, by icode:
  - 8 (call) -> valC
  - 7 (jXX) -> valC if registered cnd=1, else valP
  - 9 (ret) -> valM
  - all other icodes -> valP
REQ-027 Next-PC arithmetic is plain 64-bit selection with no adjustment; wrap is the caller's concern.
REQ-028 PCUPD: instr_count increments; next state = PAUSE if step_mode=1, else FETCH.
REQ-029 PAUSE->FETCH on step=1; otherwise hold. step_mode deasserted while in PAUSE does not release.
REQ-030 STOP is terminal until reset; start is ignored in STOP, and stat and pc hold.
REQ-031 cycle_count increments every cycle busy=1.
REQ-032 Counters follow SAT_CNT at 32'hFFFF_FFFF (saturate when SAT_CNT=1, wrap when 0).
REQ-033 start or step asserted outside the state that honours it has no effect.

Reset
REQ-034 rst_n=0 immediately forces: state=IDLE, pc=START_PC, stat=AOK, all strobes=0, busy=0, counters=0, registered cnd=0.
REQ-035 Reset asserted mid-instruction abandons that instruction; no strobe is asserted on the following cycles.
REQ-036 Deassertion is synchronised internally; the first active edge after release sees state IDLE.

Structure
REQ-037 Shared package y86_pkg holds: icode constants (IHALT=0 ... IJXX=7, ICALL=8, IRET=9), stat codes, and the state enumeration.
REQ-038 Next-PC selection lives in combinational sub-module pc_select (inputs icode, cnd, valC, valP, valM; output new_pc).

Verification
REQ-039 start with nop, nop, halt -> 2 instructions retired, then stat=HLT, pc=0x2, instr_count=2, cycle_count=13, busy=0.
REQ-040 jXX with cnd=1, valC=0x40, valP=0x9 -> pc=0x40; repeated with cnd=0 -> pc=0x9.
REQ-041 call valC=0x100, then ret valM=0x0A -> pc sequence 0x100, then 0x0A.
REQ-042 imem_er=1 and instr_val=0 in the same FETCH -> stat=ADR (not INS), decode_en never pulses, pc unchanged.
REQ-043 step_mode=1 -> FSM enters PAUSE after PCUPD and holds 10 cycles with no strobes; step pulse -> fetch_en on the next cycle.
REQ-044 rst_n low during MEMORY with dmem_er=0 -> outputs reset immediately, wb_en never asserted; the next start runs from START_PC.
